dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder for the memory stage of the pipelined processor. It accepts one read or write request at a time from the memory stage and services it after a fixed, parameterised latency. While a request is in flight it drives `active` to stall the pipeline. It returns read data with a one-cycle `ready` pulse and flags misaligned or out-of-range accesses.

## Interface
- `DEPTH`, default 256: number of 32-bit words; must be a power of two, ≥ 2.
- `LATENCY`, default 4: cycles spent in BUSY; legal range 1–255.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_read`  in  1  read request; held by the requester until the `ready` cycle.
- `req_write`  in  1  write request; held like `req_read`.
- `addr`  in  32  byte address (ALU result from the memory stage).
- `wdata`  in  32  store data.
- `active`  out  1  stall; combinational.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  completion was a faulted access; valid only with `ready`.
- `rdata`  out  32  read data; registered, holds until the next completed read.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `req_read | req_write`: capture `addr`, `wdata` and the op, load `cnt = LATENCY-1`, and go to BUSY.
  - If both request lines are high, the op is a write and the read is dropped.
- BUSY:
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: go to DONE. At the same edge, perform the access:
    - write: `mem[idx] <= wdata_q`
    - read: `rdata <= mem[idx]`
- DONE: `ready = 1` for exactly this cycle, then go to IDLE unconditionally. Requests seen in DONE are ignored; they are the same request just completed.
- Index and fault rules:
  - `idx = addr_q[$clog2(DEPTH)+1:2]`.
  - Fault if `addr_q[1:0] != 0` or `addr_q >= DEPTH*4`.
  - On a fault: no array write, `rdata <= 0` for reads, `err = 1` in DONE.
- `active = (state == BUSY) | (state == IDLE & (req_read | req_write))`. It is low in DONE so the pipeline advances on that edge.
- Memory array contents are not cleared by `reset`. Reads of never-written words are undefined.
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `ready` 0, `err` 0, `active` = 0 with no request present.

## Timing
- A request first seen in IDLE at cycle N produces:
  - BUSY in cycles N+1 … N+LATENCY
  - DONE, `ready` = 1 and `rdata` valid in cycle N+LATENCY+1
  - IDLE in N+LATENCY+2
- Total stall: `active` is high for LATENCY+1 cycles (N … N+LATENCY).
- Back-to-back requests have a minimum spacing of LATENCY+2 cycles between acceptances.
- Write visibility: a read accepted after a write's DONE cycle returns the new data.
- `reset` asserted during BUSY returns the FSM to IDLE at that edge. No array write occurs and no `ready` is produced.
- `reset` asserted in DONE: the write already landed, but `ready` is forced 0 from the reset edge.
- Request lines changing during BUSY have no effect; the captured values are used.
- `LATENCY=1`: one BUSY cycle, `ready` at N+2.

## Test plan
- Write then read, default params:
  - Stimulus: write `addr=0x10`, `wdata=0xDEADBEEF` at cycle 2; hold until `ready`; then read `0x10`.
  - Required: `active` high cycles 2–6, `ready` at 7, `err=0`; read returns `0xDEADBEEF` with `ready` 5 cycles after the read's acceptance.
- Misaligned access:
  - Stimulus: read `addr=0x11`.
  - Required: `ready` with `err=1`, `rdata=0`.
  - Stimulus: write `addr=0x12`, then read `0x10`.
  - Required: `mem[4]` is unchanged.
- Out-of-range access:
  - Stimulus: write `addr=0x400` (`DEPTH=256`).
  - Required: `err=1`, no aliasing; a read of `addr=0x0` returns its prior value.
- Simultaneous request lines:
  - Stimulus: `req_read=req_write=1`, `addr=0x20`, `wdata=0x5A5A5A5A`.
  - Required: treated as a write; a subsequent read of `0x20` returns `0x5A5A5A5A`, and `rdata` did not change on the combined request.
- Reset mid-BUSY:
  - Stimulus: write `0x1111_1111` to `0x8`, then assert `reset` in the 2nd BUSY cycle.
  - Required: no `ready`, state IDLE; a later read of `0x8` returns the old value.
- `LATENCY=1` build:
  - Stimulus: a read.
  - Required: `ready` exactly 2 cycles after acceptance, `active` high for 2 cycles; back-to-back requests accepted every 3 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data-memory responder for the memory stage. Accepts
//            one read or write at a time, services it after LATENCY cycles in
//            BUSY, then pulses ready for one cycle (DONE). Misaligned and
//            out-of-range accesses complete with err set and touch nothing.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  cycles spent in BUSY (1..255)
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   req_read   in   1   read request, held until the ready cycle
//   req_write  in   1   write request, held until the ready cycle
//   addr       in  32   byte address
//   wdata      in  32   store data
//   active     out  1   pipeline stall (combinational)
//   ready      out  1   one-cycle completion pulse
//   err        out  1   completed access faulted (valid with ready)
//   rdata      out 32   read data, holds until the next completed read
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        active,
   output logic        ready,
   output logic        err,
   output logic [31:0] rdata
);

   localparam int          c_aw       = $clog2(DEPTH);
   localparam logic [7:0]  c_cnt_load = 8'(LATENCY - 1);
   // One bit wider than the address so DEPTH*4 never wraps.
   localparam logic [32:0] c_limit    = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic              r_is_write;
   logic [31:0]       r_rdata;
   logic              r_ready;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH];

   logic [c_aw-1:0]   w_idx;
   logic              w_fault;
   logic              w_finish;
   logic              w_req;

   assign w_req    = req_read | req_write;
   assign w_idx    = r_addr[c_aw+1:2];
   assign w_fault  = (r_addr[1:0] != 2'b00) | ({1'b0, r_addr} >= c_limit);
   // Last BUSY cycle: the access is performed on the edge that enters DONE.
   assign w_finish = (r_state == BUSY) && (r_cnt == 8'd0);

   // Low in DONE so the pipeline advances on the completion edge.
   assign active = (r_state == BUSY) | ((r_state == IDLE) & w_req);
   assign ready  = r_ready;
   assign err    = r_err;
   assign rdata  = r_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= 8'd0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_is_write <= 1'b0;
         r_rdata    <= 32'd0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               if (w_req) begin
                  r_addr     <= addr;
                  r_wdata    <= wdata;
                  // A combined request is a write; the read is dropped.
                  r_is_write <= req_write;
                  r_cnt      <= c_cnt_load;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_state <= DONE;
                  r_ready <= 1'b1;
                  r_err   <= w_fault;
                  if (!r_is_write) begin
                     r_rdata <= w_fault ? 32'd0 : r_mem[w_idx];
                  end
               end
            end
            DONE: begin
               // Requests still high here belong to the access just finished.
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Storage is deliberately not reset; a reset during BUSY suppresses the
   // pending write because the write and the DONE transition share an edge.
   always_ff @(posedge clk) begin
      if (!reset && w_finish && r_is_write && !w_fault) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

endmodule

`default_nettype wire
